// File: rtl/pc_sequencer.sv
// Program-address sequencer: advances, branches, calls and returns the instruction address
// using a return-address stack, and takes prioritised interrupts plus one exception.
module pc_sequencer #(
    parameter int ADDR_W      = 15,
    parameter int STACK_DEPTH = 256,
    parameter int NUM_IRQ     = 7,
    parameter int VEC_BASE    = 2,
    localparam int SP_W       = $clog2(STACK_DEPTH) + 1,
    localparam int IDX_W      = $clog2(STACK_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic [3:0]         m_oper,
    input  logic [ADDR_W-1:0]  data_addr,
    input  logic               eq,
    input  logic               lt,
    input  logic               gt,
    input  logic               aeq,
    input  logic               hlt,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               exc,
    output logic [ADDR_W-1:0]  addr,
    output logic [SP_W-1:0]    sp,
    output logic               in_isr,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               irq_done,
    output logic               stack_ovf,
    output logic               stack_unf,
    output logic [1:0]         dbg_state
);
    localparam logic [3:0] OP_JEQ  = 4'd1;
    localparam logic [3:0] OP_JGT  = 4'd2;
    localparam logic [3:0] OP_JLT  = 4'd3;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_NEX  = 4'd6;
    localparam logic [3:0] OP_CALL = 4'd7;
    localparam logic [3:0] OP_RET  = 4'd8;
    localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] VEC_EXC = ADDR_W'(VEC_BASE + NUM_IRQ);

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_ISR = 2'd1, ST_FAULT = 2'd2} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0]  stack_ram [STACK_DEPTH];
    logic [ADDR_W-1:0]  addr_d, addr_inc, push_val, top, irq_vec;
    logic [SP_W-1:0]    sp_d, isr_sp_q, isr_sp_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d, irq_sel, ack_d;
    logic               push, done_d, ovf_d, unf_d, flag;

    assign addr_inc = addr + ADDR_W'(1);
    assign top      = stack_ram[IDX_W'(sp - SP_W'(1))];

    // Lowest-index pending line wins; loop runs high-to-low so the last hit is the lowest.
    always_comb begin
        irq_sel = '0;
        irq_vec = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                irq_sel    = '0;
                irq_sel[i] = 1'b1;
                irq_vec    = ADDR_W'(VEC_BASE + i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr;
        sp_d      = sp;
        isr_sp_d  = isr_sp_q;
        pending_d = pending_q | irq;
        ack_d     = '0;
        done_d    = 1'b0;
        ovf_d     = stack_ovf;
        unf_d     = stack_unf;
        push      = 1'b0;
        push_val  = '0;
        flag      = 1'b0;
        if (step && state_q != ST_FAULT) begin
            if (exc || (state_q == ST_RUN && |pending_q)) begin
                if (sp == SP_FULL) begin
                    ovf_d   = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    push     = 1'b1;
                    push_val = (m_oper == OP_NEX) ? addr_inc : addr;
                    sp_d     = sp + SP_W'(1);
                    addr_d   = exc ? VEC_EXC : irq_vec;
                    if (state_q == ST_RUN) isr_sp_d = sp;
                    state_d  = ST_ISR;
                    if (!exc) begin
                        ack_d     = irq_sel;
                        pending_d = (pending_q & ~irq_sel) | irq;
                    end
                end
            end else begin
                case (m_oper)
                    OP_JEQ, OP_JGT, OP_JLT: begin
                        flag   = (m_oper == OP_JEQ) ? eq : (m_oper == OP_JGT) ? gt : lt;
                        addr_d = (flag | (aeq & eq)) ? data_addr : addr_inc;
                    end
                    OP_JMP: addr_d = data_addr;
                    OP_NEX: addr_d = hlt ? addr : addr_inc;
                    OP_CALL: begin
                        if (sp == SP_FULL) begin
                            ovf_d   = 1'b1;
                            state_d = ST_FAULT;
                        end else begin
                            push     = 1'b1;
                            push_val = addr_inc;
                            sp_d     = sp + SP_W'(1);
                            addr_d   = data_addr;
                        end
                    end
                    OP_RET: begin
                        if (sp == '0) begin
                            unf_d   = 1'b1;
                            state_d = ST_FAULT;
                        end else begin
                            addr_d = top;
                            sp_d   = sp - SP_W'(1);
                            if (state_q == ST_ISR && sp_d == isr_sp_q) begin
                                state_d = ST_RUN;
                                done_d  = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        in_isr    = (state_q == ST_ISR);
        dbg_state = state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            sp        <= '0;
            isr_sp_q  <= '0;
            pending_q <= '0;
            irq_ack   <= '0;
            irq_done  <= 1'b0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            addr      <= addr_d;
            sp        <= sp_d;
            isr_sp_q  <= isr_sp_d;
            pending_q <= pending_d;
            irq_ack   <= ack_d;
            irq_done  <= done_d;
            stack_ovf <= ovf_d;
            stack_unf <= unf_d;
        end
    end

    // Stack storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (push) stack_ram[sp[IDX_W-1:0]] <= push_val;
    end
endmodule
